// File: rtl/qracc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qracc_pkg
// Description : Shared types and constants for the QRAcc SRAM arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package qracc_pkg;

    localparam int QRACC_NUM_ROWS = 128;
    localparam int QRACC_NUM_COLS = 32;
    localparam int QRACC_ADDR_W   = $clog2(QRACC_NUM_ROWS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT_RD = 2'd2
    } sram_arb_state_t;

    typedef struct packed {
        logic                      wr;
        logic [QRACC_ADDR_W-1:0]   addr;
        logic [QRACC_NUM_COLS-1:0] wdata;
    } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/qracc_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : qracc_rr_pick
// Description : Combinational one-hot winner search starting at ptr, wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module qracc_rr_pick #(
    parameter int numReq = 2,
    parameter int PTR_W  = $clog2(numReq)
) (
    input  logic [numReq-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [numReq-1:0] grant,
    output logic [PTR_W-1:0]  grant_idx,
    output logic              any
);

    always_comb begin : p_pick
        int               idx;
        logic [PTR_W-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int i = 0; i < numReq; i++) begin
            idx = int'(ptr) + i;
            if (idx >= numReq) begin
                idx = idx - numReq;
            end
            sel = PTR_W'(idx);
            if (!any && req[sel]) begin
                grant[sel] = 1'b1;
                grant_idx  = sel;
                any        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qracc_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : qracc_sram_arbiter
// Description : Shares the seq_acc SRAM port between requesters, one
//               transaction at a time, locked out while a MAC is active.
//               QRACC_ARB_FIXED_PRIO_EN selects fixed (lowest index) priority.
// Revision    : 1.0 - initial release
// ============================================================================
module qracc_sram_arbiter
    import qracc_pkg::*;
#(
    parameter int numRows = QRACC_NUM_ROWS,
    parameter int numCols = QRACC_NUM_COLS,
    parameter int numReq  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [numReq-1:0]                      req_valid_i,
    input  logic [numReq-1:0]                      req_wr_i,
    input  logic [numReq-1:0][$clog2(numRows)-1:0] req_addr_i,
    input  logic [numReq-1:0][numCols-1:0]         req_wdata_i,
    output logic [numReq-1:0]                      req_ready_o,
    output logic [numReq-1:0]                      rsp_valid_o,
    output logic [numCols-1:0]                     rsp_data_o,
    input  logic                                   mac_active_i,
    output logic                                   sram_busy_o,
    output logic                                   rq_valid_o,
    output logic                                   rq_wr_o,
    output logic [$clog2(numRows)-1:0]             addr_o,
    output logic [numCols-1:0]                     wr_data_o,
    input  logic                                   rq_ready_i,
    input  logic                                   rd_valid_i,
    input  logic [numCols-1:0]                     rd_data_i
);

    localparam int ADDR_W = $clog2(numRows);
    localparam int PTR_W  = $clog2(numReq);

    sram_arb_state_t     r_state;
    sram_arb_state_t     w_state_nxt;
    logic                w_grant_fire;
    logic                w_rsp_fire;
    logic [numReq-1:0]   w_grant;
    logic [PTR_W-1:0]    w_grant_idx;
    logic                w_any;
    logic [PTR_W-1:0]    w_pick_ptr;

    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [numCols-1:0]  r_wdata;
    logic [PTR_W-1:0]    r_owner;

    qracc_rr_pick #(
        .numReq (numReq),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req       (req_valid_i),
        .ptr       (w_pick_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any       (w_any)
    );

`ifdef QRACC_ARB_FIXED_PRIO_EN
    assign w_pick_ptr = '0;
`else
    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant_fire) begin
            r_ptr <= (w_grant_idx == PTR_W'(numReq - 1)) ? '0 : w_grant_idx + PTR_W'(1);
        end
    end

    assign w_pick_ptr = r_ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // MAC activity only gates new grants; an accepted transaction always completes.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any && !mac_active_i) begin
                    w_grant_fire = 1'b1;
                    w_state_nxt  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rq_ready_i) begin
                    w_state_nxt = r_wr ? S_IDLE : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (rd_valid_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_owner <= '0;
        end else if (w_grant_fire) begin
            r_wr    <= req_wr_i[w_grant_idx];
            r_addr  <= req_addr_i[w_grant_idx];
            r_wdata <= req_wdata_i[w_grant_idx];
            r_owner <= w_grant_idx;
        end
    end

    // Handshake pulses are masked during reset so a dropped read never responds.
    assign w_rsp_fire  = (r_state == S_WAIT_RD) && rd_valid_i && !rst;
    assign req_ready_o = {numReq{w_grant_fire && !rst}} & w_grant;
    assign rsp_data_o  = w_rsp_fire ? rd_data_i : '0;

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < numReq; i++) begin
            rsp_valid_o[i] = w_rsp_fire && (r_owner == PTR_W'(i));
        end
    end

    assign sram_busy_o = (r_state != S_IDLE);
    assign rq_valid_o  = (r_state == S_ISSUE);
    assign rq_wr_o     = r_wr;
    assign addr_o      = r_addr;
    assign wr_data_o   = r_wdata;

endmodule
`default_nettype wire
